// File: rtl/frame_pixel_writer.sv
// frame_pixel_writer: packs an 8-bit pixel stream four per word into frame memory writes.
// Optional FRAME_PIXEL_WRITER_THRESHOLD_EN adds a threshold input that binarises pixels.
module frame_pixel_writer #(
  parameter int ADDR_W    = 15,
  parameter int MAX_WORDS = 32768
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic [ADDR_W-1:0] base_addr,
`ifdef FRAME_PIXEL_WRITER_THRESHOLD_EN
  input  logic [7:0]        threshold,
`endif
  input  logic [7:0]        px_data,
  input  logic              px_valid,
  input  logic              px_sop,
  input  logic              px_eop,
  output logic              px_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic              sop_error,
  output logic [ADDR_W:0]   words_written
);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  state_t state, nxt;
  logic [ADDR_W-1:0] base;
  logic [1:0] cnt, lane;
  logic [23:0] pend;
  logic [7:0] pix;
  logic [31:0] wdata;
  logic [ADDR_W:0] off;
  logic acc, full, pack, wr, arm_ok;
`ifdef FRAME_PIXEL_WRITER_THRESHOLD_EN
  assign pix = (px_data >= threshold) ? 8'hFF : 8'h00;
`else
  assign pix = px_data;
`endif
  assign px_ready       = state != IDLE;
  assign busy           = state == ARMED || state == CAPTURE;
  assign mem_clken      = 1'b1;
  assign mem_chipselect = mem_write;
  assign acc    = px_valid & px_ready;
  assign full   = words_written == (ADDR_W+1)'(MAX_WORDS);
  assign arm_ok = arm & (state == IDLE || state == DONE);
  assign pack   = acc & ((px_sop & busy) | (!px_sop & state == CAPTURE & !full));
  // a sop always restarts packing at lane 0 and word offset 0
  assign lane   = px_sop ? 2'd0 : cnt;
  assign off    = px_sop ? '0 : words_written;
  assign wr     = pack & (lane == 2'd3 | px_eop);
  assign wdata  = ({8'h0, pend} & ((32'h1 << {lane, 3'b0}) - 32'h1)) | ({24'h0, pix} << {lane, 3'b0});
  always_comb begin
    nxt = state;
    if (arm_ok) nxt = ARMED;
    else if (acc & px_eop & (state == CAPTURE || (state == ARMED && px_sop))) nxt = DONE;
    else if (acc & px_sop & state == ARMED) nxt = CAPTURE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      base           <= '0;
      cnt            <= '0;
      pend           <= '0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_byteenable <= '0;
      mem_writedata  <= '0;
      words_written  <= '0;
      frame_done     <= 1'b0;
      overflow       <= 1'b0;
      sop_error      <= 1'b0;
    end else begin
      state      <= nxt;
      frame_done <= nxt == DONE && state != DONE;
      mem_write  <= wr;
      if (wr) begin
        mem_address    <= base + off[ADDR_W-1:0];
        mem_byteenable <= 4'hF >> (2'd3 - lane);
        mem_writedata  <= wdata;
      end
      if (pack) begin
        cnt  <= wr ? 2'd0 : lane + 2'd1;
        pend <= wdata[23:0];
      end
      if (arm_ok) begin
        base          <= base_addr;
        overflow      <= 1'b0;
        sop_error     <= 1'b0;
        words_written <= '0;
        cnt           <= '0;
      end else begin
        if (wr) words_written <= off + 1'b1;
        else if (pack & px_sop) words_written <= '0;
        if (acc & state == CAPTURE & px_sop) sop_error <= 1'b1;
        if (acc & state == CAPTURE & !px_sop & full) overflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_frame_pixel_writer.sv
// tb_frame_pixel_writer: directed checks of packing, wrap, overflow, sop restart and reset abort.
module tb_frame_pixel_writer;
  logic clk = 0, reset = 1, arm = 0, px_valid = 0, px_sop = 0, px_eop = 0;
  logic [14:0] base_addr = '0;
  logic [7:0] px_data = '0;
`ifdef FRAME_PIXEL_WRITER_THRESHOLD_EN
  logic [7:0] threshold = 8'h80;
`endif
  logic px_ready, mem_chipselect, mem_write, mem_clken, busy, frame_done, overflow, sop_error;
  logic [14:0] mem_address;
  logic [3:0] mem_byteenable;
  logic [31:0] mem_writedata;
  logic [15:0] words_written;
  logic px_ready2, mem_chipselect2, mem_write2, mem_clken2, busy2, frame_done2, overflow2, sop_error2;
  logic [14:0] mem_address2;
  logic [3:0] mem_byteenable2;
  logic [31:0] mem_writedata2;
  logic [15:0] words_written2;
  int n_chk = 0, n_fail = 0, fd_cnt = 0, w2_cnt = 0;
  logic fd_w = 0;
  logic [63:0] wq[$];

  always #5 clk = ~clk;

  frame_pixel_writer dut (
    .clk(clk), .reset(reset), .arm(arm), .base_addr(base_addr),
`ifdef FRAME_PIXEL_WRITER_THRESHOLD_EN
    .threshold(threshold),
`endif
    .px_data(px_data), .px_valid(px_valid), .px_sop(px_sop), .px_eop(px_eop), .px_ready(px_ready),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken), .busy(busy),
    .frame_done(frame_done), .overflow(overflow), .sop_error(sop_error), .words_written(words_written));

  frame_pixel_writer #(.MAX_WORDS(2)) dut2 (
    .clk(clk), .reset(reset), .arm(arm), .base_addr(base_addr),
`ifdef FRAME_PIXEL_WRITER_THRESHOLD_EN
    .threshold(threshold),
`endif
    .px_data(px_data), .px_valid(px_valid), .px_sop(px_sop), .px_eop(px_eop), .px_ready(px_ready2),
    .mem_address(mem_address2), .mem_byteenable(mem_byteenable2), .mem_chipselect(mem_chipselect2),
    .mem_write(mem_write2), .mem_writedata(mem_writedata2), .mem_clken(mem_clken2), .busy(busy2),
    .frame_done(frame_done2), .overflow(overflow2), .sop_error(sop_error2), .words_written(words_written2));

  always @(negedge clk) begin
    if (mem_write) wq.push_back({13'h0, mem_address, mem_byteenable, mem_writedata});
    if (mem_write2) w2_cnt++;
    if (frame_done) begin
      fd_cnt++;
      fd_w = mem_write;
    end
  end

  function automatic logic [63:0] ent(input logic [14:0] a, input logic [3:0] be, input logic [31:0] d);
    return {13'h0, a, be, d};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_arm(input logic [14:0] b);
    @(negedge clk);
    px_valid = 0;
    arm = 1;
    base_addr = b;
    @(negedge clk);
    arm = 0;
    wq.delete();
    fd_cnt = 0;
    fd_w = 0;
  endtask

  task automatic beat(input logic [7:0] d, input logic s, input logic e);
    @(negedge clk);
    px_data = d;
    px_valid = 1;
    px_sop = s;
    px_eop = e;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    px_valid = 0;
    px_sop = 0;
    px_eop = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) beat(start + 8'(i), i == 0, i == n - 1);
    idle(3);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, px_ready, 0);
    check({tag, "_write"}, {mem_write, mem_chipselect}, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_flags"}, {frame_done, overflow, sop_error}, 0);
    check({tag, "_mem"}, {mem_address, mem_byteenable, mem_writedata}, 0);
    check({tag, "_ww"}, words_written, 0);
    check({tag, "_clken"}, mem_clken, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    reset = 0;
    @(negedge clk);
    check("idle_ready", px_ready, 0);

    do_arm(15'h0100);
    check("armed_busy", {busy, px_ready}, 2'b11);
    frame(8'h01, 8);
    check("f8_nwr", wq.size(), 2);
    check("f8_w0", wq[0], ent(15'h0100, 4'hF, 32'h04030201));
    check("f8_w1", wq[1], ent(15'h0101, 4'hF, 32'h08070605));
    check("f8_ww", words_written, 2);
    check("f8_done", {fd_cnt[1:0], fd_w}, {2'd1, 1'b1});
    check("f8_idle", {busy, px_ready}, 2'b01);
    frame(8'h33, 4);
    check("done_drop", wq.size(), 2);

    do_arm(15'h0200);
    beat(8'hEE, 0, 0);
    frame(8'h01, 6);
    check("f6_nwr", wq.size(), 2);
    check("f6_w0", wq[0], ent(15'h0200, 4'hF, 32'h04030201));
    check("f6_w1", wq[1], ent(15'h0201, 4'b0011, 32'h00000605));

    do_arm(15'h7FFF);
    frame(8'h10, 12);
    check("wrap_nwr", wq.size(), 3);
    check("wrap_w0", wq[0], ent(15'h7FFF, 4'hF, 32'h13121110));
    check("wrap_w1", wq[1], ent(15'h0000, 4'hF, 32'h17161514));
    check("wrap_w2", wq[2], ent(15'h0001, 4'hF, 32'h1B1A1918));
    check("wrap_ww", words_written, 3);

    do_arm(15'h0040);
    w2_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      beat(8'(i + 1), i == 0, i == 15);
      if (i == 11) check("ovf_drain", {px_ready2, busy2, overflow2}, 3'b111);
    end
    idle(3);
    check("ovf_nwr", w2_cnt, 2);
    check("ovf_flag", {overflow2, words_written2}, {1'b1, 16'd2});
    check("ovf_done", busy2, 0);
    check("ovf_main", {overflow, words_written}, {1'b0, 16'd4});

    do_arm(15'h0300);
    beat(8'hA1, 1, 0);
    beat(8'hA2, 0, 0);
    beat(8'hA3, 0, 0);
    frame(8'hB1, 5);
    check("sop_nwr", wq.size(), 2);
    check("sop_w0", wq[0], ent(15'h0300, 4'hF, 32'hB4B3B2B1));
    check("sop_w1", wq[1], ent(15'h0301, 4'b0001, 32'h000000B5));
    check("sop_err", {sop_error, words_written}, {1'b1, 16'd2});
    do_arm(15'h0000);
    check("arm_clear", {sop_error, overflow, words_written}, 0);

    beat(8'h01, 1, 0);
    beat(8'h02, 0, 0);
    beat(8'h03, 0, 0);
    @(negedge clk);
    px_valid = 0;
    reset = 1;
    @(negedge clk);
    check_reset_values("abort");
    reset = 0;
    repeat (6) @(negedge clk);
    check("abort_nwr", wq.size(), 0);

`ifdef FRAME_PIXEL_WRITER_THRESHOLD_EN
    do_arm(15'h0010);
    beat(8'h7F, 1, 0);
    beat(8'h80, 0, 0);
    beat(8'h00, 0, 0);
    beat(8'hFF, 0, 1);
    idle(3);
    check("thr_nwr", wq.size(), 1);
    check("thr_w0", wq[0], ent(15'h0010, 4'hF, 32'hFF00FF00));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
